// File: rtl/tile_debug_mux_pkg.sv
// ---------------------------------------------------------------------------
// tile_debug_mux_pkg
// Shared types and constants for the per-tile debug read router.
//   cache_line_t      : one debug beat (one cache line)
//   debug_mux_state_t : router FSM states
//   DEBUG_PAD_WORD    : 32-bit filler pattern used for padded beats
// ---------------------------------------------------------------------------
package tile_debug_mux_pkg;

   localparam int unsigned CACHE_LINE_W = 512;

   typedef logic [CACHE_LINE_W-1:0] cache_line_t;

   localparam logic [31:0] DEBUG_PAD_WORD = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      PAD,
      DRAIN
   } debug_mux_state_t;

endpackage

// File: rtl/tile_debug_mux_out.sv
// ---------------------------------------------------------------------------
// debug_out_reg
// Single-entry valid/ready output register holding one beat plus its last bit.
//   clk, rstn         : clock, synchronous active-low reset
//   load_i            : capture data_i/last_i (caller only loads when ready_o)
//   data_i, last_i    : incoming beat
//   rready_i          : downstream ready
//   data_o, valid_o,
//   last_o            : registered beat presented downstream
//   ready_o           : register can accept a beat this cycle
// ---------------------------------------------------------------------------
module debug_out_reg #(
   parameter int unsigned DATA_W = 512
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              rready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              last_o,
   output logic              ready_o
);

   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              last_q;

   // Empty, or the held beat leaves this cycle: full throughput with one entry.
   assign ready_o = !valid_q || rready_i;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
         last_q  <= last_i;
      end else if (rready_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;

endmodule

// File: rtl/tile_debug_mux.sv
// ---------------------------------------------------------------------------
// tile_debug_mux
// Routes each debug read burst from the PCI arbiter's tile port to one of
// N_COMP component debug buses and always returns exactly arlen+1 beats.
// Out-of-range components are answered with pad beats, short component
// bursts are padded, long component bursts are drained and discarded.
//   clk, rstn                    : clock, synchronous active-low reset
//   dbg_arvalid/arlen/comp       : request pulse, burst length-1, component id
//   dbg_rready                   : PCI read-data ready
//   dbg_rdata/rvalid/rlast       : registered read beat towards PCI
//   comp_arvalid                 : one-hot one-cycle request to a component
//   comp_arlen                   : latched burst length
//   comp_rready                  : per-component ready
//   comp_rdata/rvalid/rlast      : component beats
//   err_flags                    : sticky [0] overlap, [1] short, [2] long
// ---------------------------------------------------------------------------
module tile_debug_mux
   import tile_debug_mux_pkg::*;
#(
   parameter int unsigned N_COMP   = 8,
   parameter int unsigned DATA_W   = 512,
   parameter logic [31:0] PAD_WORD = DEBUG_PAD_WORD
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          dbg_arvalid,
   input  logic [7:0]                    dbg_arlen,
   input  logic [7:0]                    dbg_comp,
   input  logic                          dbg_rready,
   output logic [DATA_W-1:0]             dbg_rdata,
   output logic                          dbg_rvalid,
   output logic                          dbg_rlast,
   output logic [N_COMP-1:0]             comp_arvalid,
   output logic [7:0]                    comp_arlen,
   output logic [N_COMP-1:0]             comp_rready,
   input  logic [N_COMP-1:0][DATA_W-1:0] comp_rdata,
   input  logic [N_COMP-1:0]             comp_rvalid,
   input  logic [N_COMP-1:0]             comp_rlast,
   output logic [2:0]                    err_flags
);

   localparam int unsigned       SEL_W    = (N_COMP > 1) ? $clog2(N_COMP) : 1;
   localparam logic [8:0]        N_COMP_L = 9'(N_COMP);
   localparam logic [N_COMP-1:0] ONE      = 1;
   localparam logic [DATA_W-1:0] PAD_LINE = {(DATA_W/32){PAD_WORD}};

   debug_mux_state_t  state_q;
   logic [SEL_W-1:0]  sel_q;
   logic [7:0]        len_q;
   logic [7:0]        beat_cnt_q;
   logic [N_COMP-1:0] comp_arvalid_q;
   logic [2:0]        err_q;

   logic              out_ready;
   logic              at_last;
   logic              fwd_accept;
   logic              ld;
   logic [DATA_W-1:0] ld_data;
   logic [N_COMP-1:0] sel_oh;

   assign at_last = (beat_cnt_q == len_q);
   assign sel_oh  = ONE << sel_q;

   // Datapath: which beat (if any) enters the output register this cycle.
   always_comb begin
      comp_rready = '0;
      fwd_accept  = 1'b0;
      ld          = 1'b0;
      ld_data     = PAD_LINE;
      case (state_q)
         FWD: begin
            comp_rready = sel_oh & {N_COMP{out_ready}};
            fwd_accept  = comp_rvalid[sel_q] && out_ready;
            ld          = fwd_accept;
            ld_data     = comp_rdata[sel_q];
         end
         PAD:     ld = out_ready;
         DRAIN:   comp_rready = sel_oh;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= IDLE;
         sel_q          <= '0;
         len_q          <= '0;
         beat_cnt_q     <= '0;
         comp_arvalid_q <= '0;
         err_q          <= '0;
      end else begin
         comp_arvalid_q <= '0;
         if (dbg_arvalid && state_q != IDLE) err_q[0] <= 1'b1;
         case (state_q)
            IDLE: begin
               if (dbg_arvalid) begin
                  sel_q      <= dbg_comp[SEL_W-1:0];
                  len_q      <= dbg_arlen;
                  beat_cnt_q <= '0;
                  // Full 8-bit compare so ids such as 8'hFF never alias a real component.
                  if ({1'b0, dbg_comp} < N_COMP_L) begin
                     state_q        <= FWD;
                     comp_arvalid_q <= ONE << dbg_comp[SEL_W-1:0];
                  end else begin
                     state_q <= PAD;
                  end
               end
            end
            FWD: begin
               if (fwd_accept) begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
                  if (at_last) begin
                     if (comp_rlast[sel_q]) begin
                        state_q <= IDLE;
                     end else begin
                        err_q[2] <= 1'b1;
                        state_q  <= DRAIN;
                     end
                  end else if (comp_rlast[sel_q]) begin
                     err_q[1] <= 1'b1;
                     state_q  <= PAD;
                  end
               end
            end
            PAD: begin
               if (out_ready) begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
                  if (at_last) state_q <= IDLE;
               end
            end
            DRAIN: begin
               if (comp_rvalid[sel_q] && comp_rlast[sel_q]) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   debug_out_reg #(
      .DATA_W (DATA_W)
   ) u_out (
      .clk      (clk),
      .rstn     (rstn),
      .load_i   (ld),
      .data_i   (ld_data),
      .last_i   (at_last),
      .rready_i (dbg_rready),
      .data_o   (dbg_rdata),
      .valid_o  (dbg_rvalid),
      .last_o   (dbg_rlast),
      .ready_o  (out_ready)
   );

   assign comp_arvalid = comp_arvalid_q;
   assign comp_arlen   = len_q;
   assign err_flags    = err_q;

endmodule

// File: tb/tb_tile_debug_mux.sv
// ---------------------------------------------------------------------------
// tb_tile_debug_mux
// Directed bench for tile_debug_mux. A burst-level model predicts the beats
// each request must produce; a component responder plays scripted bursts.
// ---------------------------------------------------------------------------
module tb_tile_debug_mux;

   localparam int N_COMP = 8;
   localparam int DATA_W = 512;

   logic                          clk = 1'b0;
   logic                          rstn;
   logic                          dbg_arvalid;
   logic [7:0]                    dbg_arlen;
   logic [7:0]                    dbg_comp;
   logic                          dbg_rready;
   logic [DATA_W-1:0]             dbg_rdata;
   logic                          dbg_rvalid;
   logic                          dbg_rlast;
   logic [N_COMP-1:0]             comp_arvalid;
   logic [7:0]                    comp_arlen;
   logic [N_COMP-1:0]             comp_rready;
   logic [N_COMP-1:0][DATA_W-1:0] comp_rdata;
   logic [N_COMP-1:0]             comp_rvalid;
   logic [N_COMP-1:0]             comp_rlast;
   logic [2:0]                    err_flags;

   tile_debug_mux #(
      .N_COMP   (N_COMP),
      .DATA_W   (DATA_W),
      .PAD_WORD (32'hDEAD_BEEF)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .dbg_arvalid  (dbg_arvalid),
      .dbg_arlen    (dbg_arlen),
      .dbg_comp     (dbg_comp),
      .dbg_rready   (dbg_rready),
      .dbg_rdata    (dbg_rdata),
      .dbg_rvalid   (dbg_rvalid),
      .dbg_rlast    (dbg_rlast),
      .comp_arvalid (comp_arvalid),
      .comp_arlen   (comp_arlen),
      .comp_rready  (comp_rready),
      .comp_rdata   (comp_rdata),
      .comp_rvalid  (comp_rvalid),
      .comp_rlast   (comp_rlast),
      .err_flags    (err_flags)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] beat_word(input int id, input int k);
      logic [31:0] w;
      w = {8'(id), 8'hA5, 16'(k)};
      return {(DATA_W/32){w}};
   endfunction

   // ---------------- burst-level model ----------------
   logic [DATA_W-1:0] exp_data[$];
   logic              exp_last[$];
   logic [2:0]        exp_err;
   int                beats_seen;
   logic [DATA_W-1:0] pad_line;

   // Beat i of a burst is the component's beat i while the component still
   // has beats, pad otherwise; the burst is always len+1 beats long.
   task automatic model_request(input int comp, input int len, input int nbeats);
      for (int i = 0; i <= len; i++) begin
         if (comp < N_COMP && i < nbeats) exp_data.push_back(beat_word(comp, i));
         else                             exp_data.push_back(pad_line);
         exp_last.push_back(i == len);
      end
      if (comp < N_COMP && nbeats < len + 1) exp_err[1] = 1'b1;
      if (comp < N_COMP && nbeats > len + 1) exp_err[2] = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rstn === 1'b1 && dbg_rvalid === 1'b1 && dbg_rready === 1'b1) begin
         beats_seen++;
         if (exp_data.size() == 0) begin
            chk("extra_beat", 1'b1, 1'b0);
         end else begin
            chk("beat_data", dbg_rdata, exp_data.pop_front());
            chk("beat_last", dbg_rlast, exp_last.pop_front());
         end
      end
   end

   // ---------------- PCI ready driver ----------------
   int rr_mode = 0;
   initial begin
      dbg_rready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rr_mode == 1) dbg_rready = ~dbg_rready;
         else              dbg_rready = 1'b1;
      end
   end

   // ---------------- component responder ----------------
   int resp_n = 0;
   initial begin
      int id;
      int guard;
      bit hs;
      comp_rvalid = '0;
      comp_rlast  = '0;
      comp_rdata  = '0;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && comp_arvalid != '0) begin
            id = 0;
            for (int i = 0; i < N_COMP; i++) if (comp_arvalid[i]) id = i;
            for (int k = 0; k < resp_n && rstn; k++) begin
               comp_rvalid[id] = 1'b1;
               comp_rdata[id]  = beat_word(id, k);
               comp_rlast[id]  = (k == resp_n - 1);
               hs    = 1'b0;
               guard = 0;
               while (!hs && rstn && guard < 2000) begin
                  hs = comp_rready[id];
                  @(posedge clk);
                  guard++;
                  if (!hs) @(negedge clk);
               end
               if (guard >= 2000) chk("resp_timeout", 1'b1, 1'b0);
               if (hs) @(negedge clk);
            end
            comp_rvalid[id] = 1'b0;
            comp_rlast[id]  = 1'b0;
         end
      end
   end

   // ---------------- main sequence ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves time at T+1 (+1) where T is the cycle dbg_arvalid was high.
   task automatic request(input int comp, input int len, input int nbeats);
      beats_seen = 0;
      resp_n     = nbeats;
      model_request(comp, len, nbeats);
      dbg_arvalid = 1'b1;
      dbg_comp    = 8'(comp);
      dbg_arlen   = 8'(len);
      tick();
      dbg_arvalid = 1'b0;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while ((exp_data.size() != 0 || dbg_rvalid || comp_rvalid != '0) && g < 3000) begin
         tick();
         g++;
      end
      if (g >= 3000) chk("burst_timeout", 1'b1, 1'b0);
      repeat (3) tick();
   endtask

   task automatic check_reset_outputs();
      chk("rst_rvalid", dbg_rvalid, 1'b0);
      chk("rst_rlast", dbg_rlast, 1'b0);
      chk("rst_rdata", dbg_rdata, '0);
      chk("rst_comp_arvalid", comp_arvalid, 8'h00);
      chk("rst_comp_rready", comp_rready, 8'h00);
      chk("rst_err", err_flags, 3'b000);
   endtask

   initial begin
      pad_line    = {(DATA_W/32){32'hDEAD_BEEF}};
      exp_err     = 3'b000;
      beats_seen  = 0;
      rstn        = 1'b0;
      dbg_arvalid = 1'b0;
      dbg_arlen   = '0;
      dbg_comp    = '0;
      repeat (3) tick();
      check_reset_outputs();
      rstn = 1'b1;
      tick();

      // 1: normal burst to component 2
      request(2, 3, 4);
      chk("t1_arvalid_pulse", comp_arvalid, 8'b0000_0100);
      chk("t1_arlen", comp_arlen, 8'd3);
      tick();
      chk("t1_arvalid_off", comp_arvalid, 8'h00);
      wait_done();
      chk("t1_beats", 32'(beats_seen), 32'd4);
      chk("t1_err", err_flags, 3'b000);
      chk("t1_err_model", err_flags, exp_err);

      // 2: out-of-range component answered with pad beats
      request(8, 1, 0);
      chk("t2_no_arvalid", comp_arvalid, 8'h00);
      chk("t2_rvalid_t1", dbg_rvalid, 1'b0);
      tick();
      chk("t2_rvalid_t2", dbg_rvalid, 1'b1);
      chk("t2_pad_lo", dbg_rdata[31:0], 32'hDEAD_BEEF);
      chk("t2_pad_hi", dbg_rdata[DATA_W-1:DATA_W-32], 32'hDEAD_BEEF);
      chk("t2_rlast_b0", dbg_rlast, 1'b0);
      wait_done();
      chk("t2_beats", 32'(beats_seen), 32'd2);

      // 3: short component burst is padded
      request(0, 3, 2);
      wait_done();
      chk("t3_beats", 32'(beats_seen), 32'd4);
      chk("t3_err", err_flags, 3'b010);

      // 4: long component burst is drained
      request(1, 0, 3);
      wait_done();
      chk("t4_beats", 32'(beats_seen), 32'd1);
      chk("t4_err", err_flags, 3'b110);
      chk("t4_err_model", err_flags, exp_err);
      chk("t4_idle_rready", comp_rready, 8'h00);

      // 5: 256-beat burst under toggling back-pressure
      rr_mode = 1;
      request(4, 255, 256);
      wait_done();
      rr_mode = 0;
      tick();
      chk("t5_beats", 32'(beats_seen), 32'd256);
      chk("t5_err", err_flags, 3'b110);

      // 6: overlapping request, then reset mid-burst, then a clean burst
      request(3, 7, 8);
      tick();
      dbg_arvalid = 1'b1;
      dbg_comp    = 8'd5;
      dbg_arlen   = 8'd2;
      tick();
      dbg_arvalid = 1'b0;
      exp_err[0]  = 1'b1;
      chk("t6_overlap_err", err_flags, 3'b111);
      chk("t6_arlen_held", comp_arlen, 8'd7);
      rstn = 1'b0;
      exp_data.delete();
      exp_last.delete();
      exp_err = 3'b000;
      repeat (3) tick();
      check_reset_outputs();
      rstn = 1'b1;
      repeat (4) tick();
      chk("t6_quiet_after_rst", dbg_rvalid, 1'b0);
      request(2, 3, 4);
      wait_done();
      chk("t6_beats", 32'(beats_seen), 32'd4);
      chk("t6_err", err_flags, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
